lfsr_prbs_gen: RTL and testbench

//  Parametrised Fibonacci LFSR pseudo-random sequence generator; successor to the fixed 4-bit LFSR.

---
 rtl/lfsr_pkg.sv | 27 ++
 rtl/lfsr_prbs_gen_core.sv | 67 ++++++
 rtl/lfsr_prbs_gen.sv | 98 +++++++++
 tb/tb_lfsr_prbs_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and the Fibonacci next-state helper for the LFSR PRBS generator family.
package lfsr_pkg;

  // Maximal-length tap masks for nxt = {^(state & taps), state[W-1:1]}.
  localparam logic [3:0]  TAPS_W4  = 4'b0011;
  localparam logic [7:0]  TAPS_W8  = 8'h1D;
  localparam logic [15:0] TAPS_W16 = 16'h6801;
  localparam logic [31:0] TAPS_W32 = 32'h0040_0007;

  localparam logic [3:0]  DEFAULT_SEED_W4  = 4'hF;
  localparam logic [7:0]  DEFAULT_SEED_W8  = 8'hFF;
  localparam logic [15:0] DEFAULT_SEED_W16 = 16'hFFFF;
  localparam logic [31:0] DEFAULT_SEED_W32 = 32'hFFFF_FFFF;

  // Operates on a zero-extended 32-bit view; bits at and above width stay zero.
  function automatic logic [31:0] lfsr_fib_next(input logic [31:0] state,
                                                input logic [31:0] taps,
                                                input int unsigned width);
    logic        fb;
    logic [31:0] nxt;
    fb  = ^(state & taps);
    nxt = state >> 1;
    nxt[5'(width - 1)] = fb;
    return nxt;
  endfunction

endpackage

// File: rtl/lfsr_prbs_gen_core.sv
// LFSR state and seed registers, load mux with zero-seed guard, and next-state feedback.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 4,
  parameter logic [WIDTH-1:0] TAPS         = TAPS_W4,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = DEFAULT_SEED_W4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             adv_i,
  output logic [WIDTH-1:0] state_o,
  output logic [WIDTH-1:0] seed_reg_o,
  output logic [WIDTH-1:0] nxt_o,
  output logic             seed_zero_o
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] seed_reg_q, seed_reg_d;
  logic [WIDTH-1:0] load_val;
  logic [31:0]      state_ext;
  logic [31:0]      taps_ext;
  logic [31:0]      nxt_wide;
  logic             unused_hi;

  always_comb begin
    state_ext              = '0;
    state_ext[WIDTH-1:0]   = state_q;
    taps_ext               = '0;
    taps_ext[WIDTH-1:0]    = TAPS;
  end

  assign nxt_wide  = lfsr_fib_next(state_ext, taps_ext, WIDTH);
  assign nxt_o     = nxt_wide[WIDTH-1:0];
  assign unused_hi = ^nxt_wide;

  // A zero seed would lock the register at all-zero, so it is replaced by the default.
  assign seed_zero_o = (seed_i == '0);
  assign load_val    = seed_zero_o ? DEFAULT_SEED : seed_i;

  always_comb begin
    state_d    = state_q;
    seed_reg_d = seed_reg_q;
    if (load_i) begin
      state_d    = load_val;
      seed_reg_d = load_val;
    end else if (adv_i) begin
      state_d = nxt_o;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DEFAULT_SEED;
      seed_reg_q <= DEFAULT_SEED;
    end else begin
      state_q    <= state_d;
      seed_reg_q <= seed_reg_d;
    end
  end

  assign state_o    = state_q;
  assign seed_reg_o = seed_reg_q;

endmodule

// File: rtl/lfsr_prbs_gen.sv
// Parametrised Fibonacci LFSR PRBS source with ready/valid output, wrap detection and period measurement.
module lfsr_prbs_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 4,
  parameter logic [WIDTH-1:0] TAPS         = TAPS_W4,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = DEFAULT_SEED_W4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] state,
  output logic             bit_out,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             lockup_err
);

  logic             adv;
  logic [WIDTH-1:0] seed_reg;
  logic [WIDTH-1:0] nxt;
  logic             seed_zero;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;
  logic [WIDTH-1:0] cnt_inc;
  logic             cnt_sat;

  // Handshake: the state is offered whenever en=1 and no load is in progress; a transfer
  // (and the step to the next state) happens on a clock edge where out_valid & out_ready.
  assign out_valid = en & ~load;
  assign adv       = out_valid & out_ready;

  lfsr_core #(
    .WIDTH        (WIDTH),
    .TAPS         (TAPS),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .seed_i      (seed),
    .adv_i       (adv),
    .state_o     (state),
    .seed_reg_o  (seed_reg),
    .nxt_o       (nxt),
    .seed_zero_o (seed_zero)
  );

  assign cnt_inc = cnt_q + 1'b1;
  assign cnt_sat = &cnt_q;

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    wrap_d   = 1'b0;
    lockup_d = 1'b0;
    if (load) begin
      cnt_d    = '0;
      lockup_d = seed_zero;
    end else if (adv) begin
      if (nxt == seed_reg) begin
        wrap_d = 1'b1;
        cnt_d  = '0;
        // A saturated count no longer reflects the true length, so keep the old period.
        if (!cnt_sat) period_d = cnt_inc;
      end else if (!cnt_sat) begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  assign bit_out    = state[0];
  assign wrap       = wrap_q;
  assign period     = period_q;
  assign lockup_err = lockup_q;

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Directed and randomized checks of lfsr_prbs_gen against a sequence-table reference model.
module tb_lfsr_prbs_gen;
  import lfsr_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-bit default instance
  logic       rst, load, en, out_ready;
  logic [3:0] seed;
  logic       out_valid, bit_out, wrap, lockup_err;
  logic [3:0] state, period;

  // 8-bit instance for the long-period check
  logic       rst8, load8, en8, rdy8;
  logic [7:0] seed8;
  logic       out_valid8, bit_out8, wrap8, lockup_err8;
  logic [7:0] state8, period8;

  lfsr_prbs_gen dut (
    .clk(clk), .rst(rst), .load(load), .seed(seed), .en(en), .out_ready(out_ready),
    .out_valid(out_valid), .state(state), .bit_out(bit_out), .wrap(wrap),
    .period(period), .lockup_err(lockup_err)
  );

  lfsr_prbs_gen #(.WIDTH(8), .TAPS(TAPS_W8), .DEFAULT_SEED(DEFAULT_SEED_W8)) dut8 (
    .clk(clk), .rst(rst8), .load(load8), .seed(seed8), .en(en8), .out_ready(rdy8),
    .out_valid(out_valid8), .state(state8), .bit_out(bit_out8), .wrap(wrap8),
    .period(period8), .lockup_err(lockup_err8)
  );

  int checks = 0;
  int errors = 0;

  // Reference: the maximal-length 4-bit sequence as listed for the default taps.
  logic [3:0] seq_tab [15] = '{4'hF, 4'h7, 4'h3, 4'h1, 4'h8, 4'h4, 4'h2, 4'h9,
                               4'hC, 4'h6, 4'hB, 4'h5, 4'hA, 4'hD, 4'hE};
  int         m_idx, m_seed_idx, m_cnt, m_period;
  bit         m_wrap, m_lock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [3:0] v);
    int r = 0;
    for (int i = 0; i < 15; i++) if (seq_tab[i] == v) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_seed_idx = 0; m_cnt = 0; m_period = 0; m_wrap = 0; m_lock = 0;
  endtask

  // One clock: drive inputs after negedge, check out_valid, then check registered outputs.
  task automatic step(input bit ld, input logic [3:0] sd, input bit e, input bit r, input string tag);
    logic [3:0] exp_state;
    load = ld; seed = sd; en = e; out_ready = r;
    #1 chk({tag, "_valid"}, 32'(out_valid), 32'(e & ~ld));
    @(posedge clk);
    m_wrap = 0; m_lock = 0;
    if (ld) begin
      if (sd == 4'h0) begin
        m_idx  = 0;
        m_lock = 1;
      end else begin
        m_idx = idx_of(sd);
      end
      m_seed_idx = m_idx;
      m_cnt      = 0;
    end else if (e && r) begin
      m_idx = (m_idx + 1) % 15;
      m_cnt++;
      if (m_idx == m_seed_idx) begin
        m_wrap   = 1;
        m_period = m_cnt;
        m_cnt    = 0;
      end
    end
    #1;
    exp_state = seq_tab[m_idx];
    chk({tag, "_state"},  32'(state),      32'(exp_state));
    chk({tag, "_bit"},    32'(bit_out),    32'(exp_state[0]));
    chk({tag, "_wrap"},   32'(wrap),       32'(m_wrap));
    chk({tag, "_period"}, 32'(period),     32'(m_period));
    chk({tag, "_lockup"}, 32'(lockup_err), 32'(m_lock));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; seed = '0; en = 1'b0; out_ready = 1'b0;
    rst8 = 1'b0; load8 = 1'b0; seed8 = '0; en8 = 1'b0; rdy8 = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    chk("rst_state",  32'(state),      32'h0000_000F);
    chk("rst_period", 32'(period),     32'h0);
    chk("rst_wrap",   32'(wrap),       32'h0);
    chk("rst_lockup", 32'(lockup_err), 32'h0);
    chk("rst_valid",  32'(out_valid),  32'h0);
    rst = 1'b1;

    // 1: free-running defaults, wrap after 15 advances
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 4'h0, 1'b1, 1'b1, "t1");
      if (i == 0) chk("t1_first", 32'(state), 32'h7);
      if (i == 3) chk("t1_fourth", 32'(state), 32'h8);
    end
    chk("t1_wrap_state",  32'(state),  32'hF);
    chk("t1_wrap_pulse",  32'(wrap),   32'h1);
    chk("t1_period",      32'(period), 32'd15);
    step(1'b0, 4'h0, 1'b1, 1'b1, "t1_post");
    chk("t1_wrap_clear", 32'(wrap), 32'h0);

    // 2: load 1001 and run a full cycle
    step(1'b1, 4'h9, 1'b1, 1'b1, "t2_load");
    chk("t2_seed_state", 32'(state), 32'h9);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 4'h0, 1'b1, 1'b1, "t2");
      if (i == 0) chk("t2_second", 32'(state), 32'hC);
    end
    chk("t2_wrap_state", 32'(state), 32'h9);
    chk("t2_wrap_pulse", 32'(wrap),  32'h1);

    // 3: zero-seed load
    step(1'b1, 4'h0, 1'b1, 1'b0, "t3_load");
    chk("t3_lockup", 32'(lockup_err), 32'h1);
    chk("t3_state",  32'(state),      32'hF);
    step(1'b0, 4'h0, 1'b0, 1'b0, "t3_idle");
    chk("t3_lockup_clear", 32'(lockup_err), 32'h0);

    // 4: backpressure at 0011
    step(1'b0, 4'h0, 1'b1, 1'b1, "t4_run");
    step(1'b0, 4'h0, 1'b1, 1'b1, "t4_run");
    chk("t4_at3", 32'(state), 32'h3);
    repeat (5) step(1'b0, 4'h0, 1'b1, 1'b0, "t4_hold");
    chk("t4_held", 32'(state), 32'h3);
    step(1'b0, 4'h0, 1'b1, 1'b1, "t4_release");
    chk("t4_after", 32'(state), 32'h1);
    for (int i = 0; i < 12; i++) step(1'b0, 4'h0, 1'b1, 1'b1, "t4_rest");
    chk("t4_wrap",   32'(wrap),   32'h1);
    chk("t4_period", 32'(period), 32'd15);

    // 5: load and out_ready together at 0111
    step(1'b0, 4'h0, 1'b1, 1'b1, "t5_run");
    chk("t5_at7", 32'(state), 32'h7);
    step(1'b1, 4'hA, 1'b1, 1'b1, "t5_load");
    chk("t5_state", 32'(state), 32'hA);
    chk("t5_nowrap", 32'(wrap), 32'h0);
    for (int i = 0; i < 15; i++) step(1'b0, 4'h0, 1'b1, 1'b1, "t5");
    chk("t5_wrap", 32'(wrap), 32'h1);

    // 6: async reset mid-cycle at 0100
    step(1'b1, 4'hF, 1'b1, 1'b1, "t6_load");
    for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 1'b1, 1'b1, "t6_run");
    chk("t6_at4", 32'(state), 32'h4);
    #2 rst = 1'b0;
    #1;
    chk("t6_state",  32'(state),      32'hF);
    chk("t6_period", 32'(period),     32'h0);
    chk("t6_wrap",   32'(wrap),       32'h0);
    chk("t6_lockup", 32'(lockup_err), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Randomized mix of loads (including zero seeds), enable gaps and backpressure
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 15) == 0, 4'($urandom_range(0, 15)),
           $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, "rnd");
    end

    // 8-bit instance: maximal length 255
    chk("w8_rst_state",  32'(state8),  32'hFF);
    chk("w8_rst_period", 32'(period8), 32'h0);
    rst8 = 1'b1; en8 = 1'b1; rdy8 = 1'b1;
    for (int i = 0; i < 255; i++) begin
      @(posedge clk);
      #1;
      chk("w8_wrap",   32'(wrap8),   (i == 254) ? 32'h1 : 32'h0);
      chk("w8_period", 32'(period8), (i == 254) ? 32'd255 : 32'd0);
    end
    chk("w8_state", 32'(state8), 32'hFF);
    @(negedge clk);
    en8 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
